// File: rtl/ipd_ctrl_param.sv
// ipd_ctrl_param: parametrised I-PD servo controller.
// Integral acts on the error e = r - y; proportional and derivative act on the
// measurement y only. One shared signed multiplier is time-multiplexed across
// the I, P and D products by a seven-state FSM. The result is shifted right by
// FRAC and saturated to an unsigned W_OUT-bit command.
// Optional feature: define IPD_ANTIWINDUP_EN for conditional integration
// (the integrator is frozen while the last output was saturated and the error
// would push it further into saturation).
module ipd_ctrl_param #(
    parameter int W_IN  = 11,
    parameter int W_OUT = 8,
    parameter int W_K   = 16,
    parameter int FRAC  = 8,
    parameter int W_ACC = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             listo,
    input  logic             clr,
    input  logic [W_IN-1:0]  r,
    input  logic [W_IN-1:0]  y,
    input  logic [W_K-1:0]   kp,
    input  logic [W_K-1:0]   ki,
    input  logic [W_K-1:0]   kd,
    output logic [W_OUT-1:0] u,
    output logic             valid,
    output logic             busy
);

    // Signed width of e and dy, and of the full multiplier product.
    localparam int W_E = W_IN + 1;
    localparam int W_P = W_K + 1 + W_E;

    // Integrator clamp limits, symmetric around zero, in W_ACC+1 bits.
    localparam logic signed [W_ACC:0] ACC_MAX = {2'b00, {(W_ACC-1){1'b1}}};
    localparam logic signed [W_ACC:0] ACC_MIN = {2'b11, {(W_ACC-2){1'b0}}, 1'b1};

    // Largest output code, widened to the scaled-sum width.
    localparam logic signed [W_ACC+1:0] S_UMAX = {{(W_ACC+2-W_OUT){1'b0}}, {W_OUT{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAP,
        S_MI,
        S_MP,
        S_MD,
        S_SUM,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Operands captured on the listo strobe.
    logic [W_IN-1:0] r_r;
    logic [W_IN-1:0] r_y;
    logic [W_K-1:0]  r_kp;
    logic [W_K-1:0]  r_ki;
    logic [W_K-1:0]  r_kd;

    // Controller state and intermediate terms.
    logic [W_IN-1:0]         r_y_prev;
    logic signed [W_E-1:0]   r_e;
    logic signed [W_E-1:0]   r_dy;
    logic signed [W_ACC-1:0] r_integ;
    logic signed [W_ACC-1:0] r_p;
    logic signed [W_ACC-1:0] r_d;
    logic signed [W_ACC+1:0] r_s;

    logic [W_OUT-1:0] r_u;
    logic             r_valid;
    logic             r_busy;

    // Combinational datapath signals.
    logic [W_K-1:0]          w_mul_k;
    logic signed [W_E-1:0]   w_mul_x;
    logic signed [W_P-1:0]   w_prod;
    logic signed [W_ACC-1:0] w_prod_ext;
    logic signed [W_ACC:0]   w_acc_sum;
    logic signed [W_ACC-1:0] w_acc_sat;
    logic signed [W_E-1:0]   w_e;
    logic signed [W_E-1:0]   w_dy;
    logic signed [W_ACC+1:0] w_sum;
    logic                    w_out_lo;
    logic                    w_out_hi;
    logic                    w_mi_skip;
    logic                    w_capture;
    logic                    w_clear;

    assign w_capture = (r_state == S_IDLE) && en && listo;
    // A clear is honoured only when no capture happens in the same cycle.
    assign w_clear   = (r_state == S_IDLE) && en && !listo && clr;

    // Error and measurement delta, both exact in W_IN+1 signed bits.
    assign w_e  = $signed({1'b0, r_r}) - $signed({1'b0, r_y});
    assign w_dy = $signed({1'b0, r_y}) - $signed({1'b0, r_y_prev});

    // Select the multiplier operands for the state that consumes the product.
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_mul_k = r_kp;
        w_mul_x = $signed({1'b0, r_y});
        case (r_state)
            S_MI: begin
                w_mul_k = r_ki;
                w_mul_x = r_e;
            end
            S_MD: begin
                w_mul_k = r_kd;
                w_mul_x = r_dy;
            end
            default: ;
        endcase
    end

    // Coefficients are unsigned, so they enter the signed product zero-extended.
    assign w_prod     = $signed({1'b0, w_mul_k}) * w_mul_x;
    assign w_prod_ext = {{(W_ACC-W_P+1){w_prod[W_P-1]}}, w_prod[W_P-2:0]};

    // Integrator update with one guard bit, clamped instead of wrapping.
    assign w_acc_sum = $signed({r_integ[W_ACC-1], r_integ})
                     + $signed({w_prod_ext[W_ACC-1], w_prod_ext});
    assign w_acc_sat = (w_acc_sum > ACC_MAX) ? ACC_MAX[W_ACC-1:0] :
                       (w_acc_sum < ACC_MIN) ? ACC_MIN[W_ACC-1:0] :
                                               w_acc_sum[W_ACC-1:0];

    // I - P - D with two guard bits so the subtraction can never overflow.
    assign w_sum = $signed({{2{r_integ[W_ACC-1]}}, r_integ})
                 - $signed({{2{r_p[W_ACC-1]}}, r_p})
                 - $signed({{2{r_d[W_ACC-1]}}, r_d});

    // Output saturation decisions on the scaled sum.
    assign w_out_lo = r_s[W_ACC+1];
    assign w_out_hi = (r_s > S_UMAX);

`ifdef IPD_ANTIWINDUP_EN
    logic r_sat_hi;
    logic r_sat_lo;

    // Remember which way the last command saturated; cleared with the integrator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sat_hi <= 1'b0;
            r_sat_lo <= 1'b0;
        end else if (w_clear) begin
            r_sat_hi <= 1'b0;
            r_sat_lo <= 1'b0;
        end else if (r_state == S_OUT) begin
            r_sat_hi <= w_out_hi;
            r_sat_lo <= w_out_lo;
        end
    end

    // Freeze the integrator while the error drives it deeper into saturation.
    assign w_mi_skip = (r_sat_hi && !r_e[W_E-1] && (r_e != '0))
                    || (r_sat_lo &&  r_e[W_E-1]);
`else
    assign w_mi_skip = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a fixed sequence once a sample has been captured.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_capture) w_state_nxt = S_CAP;
            S_CAP:   w_state_nxt = S_MI;
            S_MI:    w_state_nxt = S_MP;
            S_MP:    w_state_nxt = S_MD;
            S_MD:    w_state_nxt = S_SUM;
            S_SUM:   w_state_nxt = S_OUT;
            S_OUT:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: each state commits its own term on the edge that leaves it.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_r      <= '0;
            r_y      <= '0;
            r_kp     <= '0;
            r_ki     <= '0;
            r_kd     <= '0;
            r_y_prev <= '0;
            r_e      <= '0;
            r_dy     <= '0;
            r_integ  <= '0;
            r_p      <= '0;
            r_d      <= '0;
            r_s      <= '0;
            r_u      <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_r    <= r;
                        r_y    <= y;
                        r_kp   <= kp;
                        r_ki   <= ki;
                        r_kd   <= kd;
                        r_busy <= 1'b1;
                    end else if (w_clear) begin
                        r_integ  <= '0;
                        r_y_prev <= '0;
                    end
                end
                S_CAP: begin
                    r_e  <= w_e;
                    r_dy <= w_dy;
                end
                S_MI: begin
                    if (!w_mi_skip) r_integ <= w_acc_sat;
                end
                S_MP: begin
                    r_p <= w_prod_ext;
                end
                S_MD: begin
                    r_d      <= w_prod_ext;
                    r_y_prev <= r_y;
                end
                S_SUM: begin
                    r_s <= w_sum >>> FRAC;
                end
                S_OUT: begin
                    r_u     <= w_out_lo ? '0 :
                               w_out_hi ? {W_OUT{1'b1}} : r_s[W_OUT-1:0];
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign u     = r_u;
    assign valid = r_valid;
    assign busy  = r_busy;

endmodule

// File: tb/tb_ipd_ctrl_param.sv
// Testbench for ipd_ctrl_param (default parameters). Expected values are
// hand-computed; the windup case follows IPD_ANTIWINDUP_EN when it is defined.
module tb_ipd_ctrl_param;

    logic        clk;
    logic        rst;
    logic        en;
    logic        listo;
    logic        clr;
    logic [10:0] r;
    logic [10:0] y;
    logic [15:0] kp;
    logic [15:0] ki;
    logic [15:0] kd;
    logic [7:0]  u;
    logic        valid;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        clr_first;
        logic [10:0] r;
        logic [10:0] y;
        logic [15:0] kp;
        logic [15:0] ki;
        logic [15:0] kd;
        int          exp_u;
    } vec_t;

    localparam int N_VEC = 19;
    vec_t vecs [N_VEC];

    ipd_ctrl_param dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .listo (listo),
        .clr   (clr),
        .r     (r),
        .y     (y),
        .kp    (kp),
        .ki    (ki),
        .kd    (kd),
        .u     (u),
        .valid (valid),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clear cycle in IDLE.
    task automatic do_clr();
        @(negedge clk);
        en  = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Strobe once, then watch the following seven edges. extra_k re-raises
    // listo for one cycle k edges after capture; drop_en_k drops en likewise.
    task automatic run_strobe(input logic [10:0] rv, input logic [10:0] yv,
                              input logic [15:0] kpv, input logic [15:0] kiv,
                              input logic [15:0] kdv, input logic clr_too,
                              input int extra_k, input int drop_en_k,
                              input int exp_u, input string name);
        int valid_cnt;
        int valid_k;
        @(negedge clk);
        en    = 1'b1;
        r     = rv;
        y     = yv;
        kp    = kpv;
        ki    = kiv;
        kd    = kdv;
        clr   = clr_too;
        listo = 1'b1;
        @(negedge clk);
        listo = 1'b0;
        clr   = 1'b0;
        // Operands must have been latched; disturb them for the rest of the run.
        r  = '1;
        y  = '0;
        kp = '1;
        ki = '1;
        kd = '1;
        check({name, " busy_after_capture"}, busy, 1);
        valid_cnt = 0;
        valid_k   = -1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (valid) begin
                valid_cnt++;
                valid_k = k;
            end
            if (k == 6) check({name, " busy_at_valid"}, busy, 0);
            listo = (k == extra_k);
            if (k == drop_en_k) en = 1'b0;
        end
        check({name, " valid_count"}, valid_cnt, 1);
        check({name, " valid_latency"}, valid_k, 6);
        check({name, " u"}, u, exp_u);
    endtask

    // Watchdog so a broken DUT can never hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;

        //            clr   r    y   kp   ki   kd  exp_u
        vecs[0]  = '{1'b1, 100, 40,   0, 256,   0,  60};  // integral ramp
        vecs[1]  = '{1'b0, 100, 40,   0, 256,   0, 120};
        vecs[2]  = '{1'b0, 100, 40,   0, 256,   0, 180};
        vecs[3]  = '{1'b0, 100, 40,   0, 256,   0, 240};
        vecs[4]  = '{1'b0, 100, 40,   0, 256,   0, 255};  // clamps high
        vecs[5]  = '{1'b1, 100, 40, 128, 256,   0,  40};  // P+I: 60 - 20
        vecs[6]  = '{1'b1, 100, 40,   0,   0,   0,   0};  // prime y_prev=40
        vecs[7]  = '{1'b0, 100, 40,   0, 256, 256,  60};  // dy = 0
        vecs[8]  = '{1'b0, 100, 50,   0, 256, 256, 100};  // 110 - 10
        vecs[9]  = '{1'b1,   0, 100, 256,  0,   0,   0};  // -100 clamps low
        vecs[10] = '{1'b1, 100, 40,   0, 256,   0,  60};  // windup run
        vecs[11] = '{1'b0, 100, 40,   0, 256,   0, 120};
        vecs[12] = '{1'b0, 100, 40,   0, 256,   0, 180};
        vecs[13] = '{1'b0, 100, 40,   0, 256,   0, 240};
        vecs[14] = '{1'b0, 100, 40,   0, 256,   0, 255};
        vecs[15] = '{1'b0, 100, 40,   0, 256,   0, 255};
        vecs[16] = '{1'b0, 100, 40,   0, 256,   0, 255};
        vecs[17] = '{1'b0, 100, 40,   0, 256,   0, 255};
`ifdef IPD_ANTIWINDUP_EN
        vecs[18] = '{1'b0, 100, 160,  0, 256,   0, 240};  // integ 300 -> 240
`else
        vecs[18] = '{1'b0, 100, 160,  0, 256,   0, 255};  // integ 480 -> 420
`endif

        rst   = 1'b0;
        en    = 1'b0;
        listo = 1'b0;
        clr   = 1'b0;
        r     = '0;
        y     = '0;
        kp    = '0;
        ki    = '0;
        kd    = '0;
        #1;
        check("reset u", u, 0);
        check("reset valid", valid, 0);
        check("reset busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            if (vecs[i].clr_first) do_clr();
            run_strobe(vecs[i].r, vecs[i].y, vecs[i].kp, vecs[i].ki, vecs[i].kd,
                       1'b0, -1, -1, vecs[i].exp_u, $sformatf("vec%0d", i));
        end

        // Asynchronous reset while the FSM is in MD.
        @(negedge clk);
        en    = 1'b1;
        r     = 11'd100;
        y     = 11'd40;
        kp    = 16'd0;
        ki    = 16'd256;
        kd    = 16'd0;
        listo = 1'b1;
        @(negedge clk);
        listo = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort u", u, 0);
        check("abort valid", valid, 0);
        check("abort busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        run_strobe(100, 40, 0, 256, 0, 1'b0, -1, -1, 60, "integ_after_reset");

        // clr together with listo: the capture wins and the integrator is kept.
        run_strobe(100, 40, 0, 256, 0, 1'b1, -1, -1, 120, "clr_with_listo");

        // en dropped one cycle into a run: the run still completes.
        run_strobe(100, 40, 0, 256, 0, 1'b0, -1, 1, 180, "en_dropped");

        // en low: listo is ignored and u holds.
        @(negedge clk);
        listo = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid) cnt++;
        end
        listo = 1'b0;
        check("disabled valid_count", cnt, 0);
        check("disabled busy", busy, 0);
        check("disabled u_held", u, 180);

        // listo while busy is dropped, not queued.
        run_strobe(100, 40, 0, 256, 0, 1'b0, 1, -1, 240, "listo_while_busy");
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid) cnt++;
        end
        check("no_queued_run valid_count", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
